// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter slice.
// Imported by the arbiter top and its round-robin picker.
package core_mem_arbiter_pkg;

    localparam int NUM_CORES_DEF = 4;
    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 8;
    localparam int MEM_LAT_DEF   = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HELD  = 2'd2
    } arb_state_e;

    // Width of a core index; kept at least 1 so a single core still has a tag.
    function automatic int core_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above prio,
// wrapping. Returns one-hot grant, winner index and an any-request flag.
module rr_pick
    import core_mem_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = core_id_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] prio_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = prio_i + IW'(k);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between cores,
// with a drain-then-acknowledge hold handshake for the VGA path.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_LAT   = MEM_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        hold_req,
    output logic                        hold_ack
);

    localparam int CW = core_id_w(NUM_CORES);

    arb_state_e state_q, state_d;
    logic [CW-1:0] prio_q, prio_d;

    logic [NUM_CORES-1:0] pick_gnt;
    logic [CW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 grant;
    logic                 drained;

    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [MEM_LAT-1:0]         pv_q, pv_d;
    logic [MEM_LAT-1:0][CW-1:0] ptag_q, ptag_d;

    logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 ack_q, ack_d;

    rr_pick #(
        .N  (NUM_CORES),
        .IW (CW)
    ) u_pick (
        .req_i  (req),
        .prio_i (prio_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign grant   = (state_q == ST_RUN) && !hold_req && pick_any;
    assign gnt     = grant ? pick_gnt : '0;
    assign drained = !(|pv_q) && !en_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (hold_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!hold_req)    state_d = ST_RUN;
                else if (drained) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!hold_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        ack_d = (state_d == ST_HELD);
    end

    // Address and write data hold their last value when idle.
    always_comb begin
        prio_d  = prio_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant) begin
            prio_d  = pick_idx + 1'b1;
            en_d    = 1'b1;
            we_d    = we[pick_idx];
            addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
            wdata_d = wdata[pick_idx*DATA_W +: DATA_W];
        end
    end

    // Tag pipeline for reads; stage 0 is loaded alongside mem_en.
    always_comb begin
        pv_d      = '0;
        ptag_d    = '0;
        pv_d[0]   = grant && !we[pick_idx];
        ptag_d[0] = pick_idx;
        for (int k = 1; k < MEM_LAT; k++) begin
            pv_d[k]   = pv_q[k-1];
            ptag_d[k] = ptag_q[k-1];
        end
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (pv_q[MEM_LAT-1]) begin
            rvalid_d[ptag_q[MEM_LAT-1]] = 1'b1;
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            prio_q   <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pv_q     <= '0;
            ptag_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            pv_q     <= pv_d;
            ptag_q   <= ptag_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
        end
    end

    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign hold_ack  = ack_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_core_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]  gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          hold_req, hold_ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .hold_req  (hold_req),
        .hold_ack  (hold_ack)
    );

    // Memory device: samples the strobe one edge after it is driven and
    // presents read data on the following cycle.
    logic [DW-1:0] dev_ram [256];
    logic [DW-1:0] rd_q;
    bit            dev_init = 0;

    always @(posedge clk) begin
        if (!dev_init) begin
            for (int a = 0; a < 256; a++) dev_ram[a] <= DW'(a) ^ 8'h99;
            dev_init <= 1;
        end else begin
            if (mem_en === 1'b1 && mem_we === 1'b1) dev_ram[mem_addr] <= mem_wdata;
            if (mem_en === 1'b1 && mem_we === 1'b0) rd_q <= dev_ram[mem_addr];
        end
    end
    assign mem_rdata = rd_q;

    // Transaction-level model: accesses are serialised in grant order,
    // a read granted in cycle g returns at the edge ending cycle g+LAT.
    typedef struct {
        int            g;
        int            core;
        logic [DW-1:0] d;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] mram [256];
    bit            m_init = 0;
    bit            started = 0;
    int            cyc = 0;
    int            m_prio = 0;
    int            m_mode = 0;
    logic          m_en = 0, m_we = 0, m_ack = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [N-1:0]  m_rvalid = '0;

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] r;
        r = '0;
        if (m_mode != 0 || hold_req || req == '0) return r;
        for (int k = 0; k < N; k++) begin
            if (req[(m_prio + k) % N]) begin
                r[(m_prio + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] eg;
        bit busy;
        int w;
        if (!m_init) begin
            for (int a = 0; a < 256; a++) mram[a] = DW'(a) ^ 8'h99;
            m_init = 1;
        end
        if (reset) begin
            rq.delete();
            m_prio = 0; m_mode = 0;
            m_en = 0; m_we = 0; m_ack = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_rvalid = '0;
            started = 1;
        end else begin
            eg = exp_gnt();
            busy = m_en;
            foreach (rq[j]) if (cyc - rq[j].g <= LAT) busy = 1;
            m_rvalid = '0;
            if (rq.size() > 0 && rq[0].g == cyc - LAT) begin
                m_rvalid[rq[0].core] = 1'b1;
                m_rdata = rq[0].d;
                void'(rq.pop_front());
            end
            if (eg != '0) begin
                w = 0;
                for (int i = 0; i < N; i++) if (eg[i]) w = i;
                m_en    = 1;
                m_we    = we[w];
                m_addr  = addr[w*AW +: AW];
                m_wdata = wdata[w*DW +: DW];
                m_prio  = (w + 1) % N;
                if (m_we) mram[m_addr] = m_wdata;
                else rq.push_back('{g: cyc, core: w, d: mram[m_addr]});
            end else begin
                m_en = 0;
                m_we = 0;
            end
            case (m_mode)
                0: if (hold_req) m_mode = 1;
                1: if (!hold_req) m_mode = 0; else if (!busy) m_mode = 2;
                default: if (!hold_req) m_mode = 0;
            endcase
            m_ack = (m_mode == 2);
        end
        cyc++;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp("gnt",       32'(gnt),       32'(exp_gnt()));
            cmp("mem_en",    32'(mem_en),    32'(m_en));
            cmp("mem_we",    32'(mem_we),    32'(m_we));
            cmp("mem_addr",  32'(mem_addr),  32'(m_addr));
            cmp("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            cmp("rvalid",    32'(rvalid),    32'(m_rvalid));
            cmp("rdata",     32'(rdata),     32'(m_rdata));
            cmp("hold_ack",  32'(hold_ack),  32'(m_ack));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        req = '0;
        hold_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        logic [N-1:0] g;
        int hold_cnt;
        hold_cnt = 0;
        for (int c = 0; c < n; c++) begin
            look();
            g = gnt;
            tick();
            for (int i = 0; i < N; i++) begin
                if (g[i]) req[i] = 1'b0;
                if (!req[i] && ($urandom % 3 == 0)) begin
                    req[i] = 1'b1;
                    we[i]  = ($urandom % 3 == 0);
                    addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
                    wdata[i*DW +: DW] = DW'($urandom);
                end
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) hold_req = 1'b0;
            end else if ($urandom % 40 == 0) begin
                hold_req = 1'b1;
                hold_cnt = $urandom_range(1, 12);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0; hold_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // single read
        look();
        cmp("t1_reset_en", 32'(mem_en), 0);
        cmp("t1_reset_ack", 32'(hold_ack), 0);
        tick();
        req = 4'b0100;
        addr[2*AW +: AW] = 8'h3C;
        look();
        cmp("t1_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0;
        look();
        cmp("t1_mem_en", 32'(mem_en), 1);
        cmp("t1_mem_addr", 32'(mem_addr), 32'h3C);
        cmp("t1_rvalid_e1", 32'(rvalid), 0);
        tick();
        look();
        cmp("t1_rvalid_e2", 32'(rvalid), 0);
        tick();
        look();
        cmp("t1_rvalid", 32'(rvalid), 32'h4);
        cmp("t1_rdata", 32'(rdata), 32'hA5);

        // fairness
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(8'h40 + i);
        for (int k = 0; k < 8; k++) begin
            look();
            cmp("t2_gnt", 32'(gnt), 32'(1 << (k % 4)));
            if (k > 0) cmp("t2_mem_en", 32'(mem_en), 1);
            tick();
        end
        req = '0;
        repeat (4) tick();

        // wrap
        do_reset();
        req = 4'b0100;
        look();
        cmp("t3_gnt_a", 32'(gnt), 32'h4);
        tick();
        req = 4'b0011;
        look();
        cmp("t3_gnt_b", 32'(gnt), 32'h1);
        tick();
        look();
        cmp("t3_gnt_c", 32'(gnt), 32'h2);
        tick();
        req = '0;
        repeat (4) tick();

        // hold with a read in flight
        do_reset();
        req = 4'b0010;
        addr[1*AW +: AW] = 8'h11;
        look();
        cmp("t4_gnt1", 32'(gnt), 32'h2);
        tick();
        req = 4'b1000;
        addr[3*AW +: AW] = 8'h22;
        hold_req = 1'b1;
        look();
        cmp("t4_nogrant", 32'(gnt), 0);
        tick();
        look();
        cmp("t4_ack_early", 32'(hold_ack), 0);
        tick();
        look();
        cmp("t4_rvalid", 32'(rvalid), 32'h2);
        cmp("t4_rdata", 32'(rdata), 32'(8'h11 ^ 8'h99));
        cmp("t4_ack_rv", 32'(hold_ack), 0);
        tick();
        look();
        cmp("t4_ack", 32'(hold_ack), 1);
        cmp("t4_held_gnt", 32'(gnt), 0);
        tick();
        hold_req = 1'b0;
        look();
        cmp("t4_ack_release", 32'(hold_ack), 1);
        cmp("t4_gnt_held", 32'(gnt), 0);
        tick();
        look();
        cmp("t4_ack_clear", 32'(hold_ack), 0);
        cmp("t4_gnt3", 32'(gnt), 32'h8);
        tick();
        req = '0;
        repeat (4) tick();

        // aborted drain
        do_reset();
        req = 4'b0001;
        look();
        cmp("t5_gnt", 32'(gnt), 32'h1);
        tick();
        req = '0;
        hold_req = 1'b1;
        tick();
        hold_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            look();
            cmp("t5_no_ack", 32'(hold_ack), 0);
            tick();
        end
        req = 4'b0010;
        look();
        cmp("t5_gnt_run", 32'(gnt), 32'h2);
        tick();
        req = '0;

        // reset mid-read
        do_reset();
        req = 4'b0100;
        addr[2*AW +: AW] = 8'h07;
        look();
        cmp("t6_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        look();
        cmp("t6_en", 32'(mem_en), 0);
        cmp("t6_addr", 32'(mem_addr), 0);
        cmp("t6_rdata", 32'(rdata), 0);
        cmp("t6_ack", 32'(hold_ack), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            look();
            cmp("t6_no_rvalid", 32'(rvalid), 0);
        end
        tick();
        req = 4'b1111;
        look();
        cmp("t6_prio0", 32'(gnt), 32'h1);
        tick();
        req = '0;

        // random traffic
        do_reset();
        rand_phase(3000);
        req = '0;
        hold_req = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Round-robin arbiter sharing one single-port data memory between the GPU cores. Each core issues at most one read or write per grant. The arbiter forwards the winning access to the memory port and routes read data back to the requesting core after a fixed latency. A hold handshake lets the VGA path take exclusive use of the memory between frames: the arbiter drains in-flight reads, then acknowledges.

Parameters:
NUM_CORES, 4, number of requesting cores (power of two, >=2)
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
MEM_LAT, 2, cycles from mem_en sample edge to valid mem_rdata (1..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  NUM_CORES  per-core access request, level, held until granted
we  in  NUM_CORES  per-core write enable (1=write, 0=read)
addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CORES*DATA_W  per-core write data, same packing
gnt  out  NUM_CORES  one-hot grant, combinational, accepted in the same cycle
rvalid  out  NUM_CORES  one-hot read-data valid, registered
rdata  out  DATA_W  read data, broadcast, valid where rvalid set
mem_en  out  1  memory access strobe, registered
mem_we  out  1  memory write strobe, registered
mem_addr  out  ADDR_W  registered
mem_wdata  out  DATA_W  registered
mem_rdata  in  DATA_W  memory read data
hold_req  in  1  VGA requests exclusive memory
hold_ack  out  1  arbiter idle, memory free for VGA, registered

Behaviour:
- Reset: state RUN, prio pointer 0, response pipeline cleared. gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata and hold_ack are all 0.
- Grant rule: gnt is non-zero only when state==RUN, hold_req==0 and req!=0.
  - Winner is the first set req bit searching upward from prio, wrapping modulo NUM_CORES.
  - Exactly one bit is set. gnt is always a subset of req.
- On a grant to core i:
  - Next edge registers mem_en=1, mem_we=we[i], mem_addr and mem_wdata from core i's slice.
  - prio <= (i+1) mod NUM_CORES.
  - With no grant, mem_en=0, mem_we=0, mem_addr and mem_wdata hold, prio holds.
- Throughput: one access per cycle. Back-to-back grants to different cores are allowed. A core re-requesting after its grant waits at most NUM_CORES-1 grants.
- Read return:
  - A read carries a valid bit and a core tag (log2 NUM_CORES bits) down a MEM_LAT-deep pipeline that starts at mem_en.
  - When the tail is valid: rvalid[tag]=1 and rdata=mem_rdata, both registered. So rvalid rises MEM_LAT+1 edges after the granting edge.
  - Writes produce no rvalid.
  - rdata holds its last value when rvalid=0.
- State machine:
  - RUN -> DRAIN when hold_req=1. In that cycle no grant is given, even if req is set.
  - DRAIN -> HELD when the pipeline has no valid entries and mem_en=0. hold_ack=1 from the edge that enters HELD.
  - HELD stays while hold_req=1. No grants; req stays pending.
  - HELD -> RUN when hold_req=0. hold_ack clears on that edge and grants resume the cycle after.
  - DRAIN -> RUN if hold_req drops before HELD is reached. hold_ack stays 0.
- Simultaneous events:
  - hold_req rising in the same cycle as req gives no grant.
  - A read in flight when hold_req rises still returns its rvalid before hold_ack.
- Reset mid-operation flushes the pipeline. Pending reads are lost, no rvalid is produced, and the cores restart their requests.
- Width rules: prio is log2(NUM_CORES) bits and wraps naturally. The arbiter does no address arithmetic.

Decomposition:
- Shared defines file:
  - CORE_ID width macro (log2 NUM_CORES)
  - Packed-bus slice macros for addr and wdata (same style as the existing per-core range macros)
  - Arbiter state encodings RUN=2'd0, DRAIN=2'd1, HELD=2'd2
- One natural sub-module: rr_pick, the combinational round-robin one-hot picker (req, prio -> gnt, winner index). It is reusable by the task scheduler.
- The response pipeline stays inline.

Test Plan:
1. Single read: reset, then req=4'b0100, we=0, addr[2]=8'h3C; mem model returns 8'hA5 -> gnt=4'b0100 the same cycle; next edge mem_en=1, mem_addr=8'h3C; 3 edges after grant rvalid=4'b0100, rdata=8'hA5.
2. Fairness: req=4'b1111 held for 8 cycles (each core re-requests immediately), prio=0 -> grant order 0,1,2,3,0,1,2,3; mem_en high every cycle.
3. Wrap: prio=3, req=4'b0011 -> gnt=4'b0001, prio becomes 1; then req=4'b0011 -> gnt=4'b0010.
4. Hold with in-flight read: grant a read from core 1, hold_req=1 the next cycle with req=4'b1000 -> no grant; rvalid[1] arrives before hold_ack=1; core 3 is granted only after hold_req=0, in the first RUN cycle.
5. Abort drain: hold_req pulses for 1 cycle during a read in flight -> hold_ack never rises; state returns to RUN.
6. Reset mid-read: assert reset one cycle after a read grant -> no rvalid afterwards, all outputs 0, prio=0.
